// File: rtl/dijkstra_pkg.sv
// Shared constants, types and status codes for the dijkstra result path tracer.
package dijkstra_pkg;

    localparam int MAX_VIRTEX_NUM   = 16;
    localparam int VIRTEX_DWIDTH    = 32;
    localparam int VIRTEX_NUM_WIDTH = 5;

    typedef logic [VIRTEX_NUM_WIDTH-1:0] vertex_t;
    typedef logic [VIRTEX_DWIDTH-1:0]    dist_t;

    // An all-ones distance marks a vertex the engine could not reach.
    localparam dist_t DIST_INF = '1;

    typedef enum logic [2:0] {
        ST_OK         = 3'd0,
        ST_UNREACH    = 3'd1,
        ST_BAD_TARGET = 3'd2,
        ST_NO_RESULT  = 3'd3,
        ST_LOOP       = 3'd4
    } trace_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WALK,
        S_EMIT,
        S_DONE
    } tracer_state_e;

endpackage

// File: rtl/dj_path_stack.sv
// LIFO holding the predecessor walk so the path can be replayed source-first.
module dj_path_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx  = AW'(cnt_q);
    assign rd_idx  = AW'(cnt_q - 1'b1);
    assign top_o   = mem_q[rd_idx];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));

    // Storage write; flush dominates so a push in the flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    // Occupancy count: flush > push > pop.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The walk hop limit keeps pushes below depth; a push into a full stack is a design bug.
    always_ff @(posedge clk) begin
        if (!rst && push_i && !flush_i) begin
            assert (!full_o) else $error("dj_path_stack: push while full");
        end
    end

endmodule

// File: rtl/dijkstra_path_tracer.sv
// Snapshots a dijkstra engine result, walks the predecessor chain from a target back to
// the source and streams the path source-first, then reports status, distance and length.
//
// state   | meaning
// IDLE    | waiting for a request; captures engine results
// CHECK   | validates snapshot, target range and reachability
// WALK    | pushes one vertex per cycle following route[] toward the source
// EMIT    | pops the stack onto the valid/ready path port
// DONE    | one-cycle done pulse with status/dist/len updated
module dijkstra_path_tracer
    import dijkstra_pkg::*;
(
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           result_rdy_i,
    input  logic                                           error_i,
    input  logic [MAX_VIRTEX_NUM-1:0][VIRTEX_DWIDTH-1:0]   dist_vect_i,
    input  logic [MAX_VIRTEX_NUM-1:0][VIRTEX_NUM_WIDTH-1:0] route_vect_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0]                    res_virt_init_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0]                    res_virt_num_i,
    output logic                                           result_lost_o,
    input  logic                                           trace_req_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0]                    trace_target_i,
    output logic                                           trace_req_rdy_o,
    output logic                                           path_valid_o,
    input  logic                                           path_ready_i,
    output logic [VIRTEX_NUM_WIDTH-1:0]                    path_vertex_o,
    output logic                                           path_last_o,
    output logic                                           trace_done_o,
    output logic [2:0]                                     trace_status_o,
    output logic [VIRTEX_DWIDTH-1:0]                       path_dist_o,
    output logic [VIRTEX_NUM_WIDTH:0]                      path_len_o
);

    localparam int IDX_W = $clog2(MAX_VIRTEX_NUM);
    localparam int LEN_W = VIRTEX_NUM_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_VIRTEX_NUM);

    tracer_state_e state_q, state_d;

    logic [MAX_VIRTEX_NUM-1:0][VIRTEX_DWIDTH-1:0]    dist_q;
    logic [MAX_VIRTEX_NUM-1:0][VIRTEX_NUM_WIDTH-1:0] route_q;
    logic          snap_valid_q;
    vertex_t       init_q, num_q, target_q;
    vertex_t       cur_q, cur_d;
    logic [LEN_W-1:0] hop_q, hop_d, hop_inc;
    logic [LEN_W-1:0] walk_len_q, walk_len_d;
    trace_status_e pend_q, pend_d;
    logic          lost_q;
    trace_status_e status_q;
    dist_t         dist_out_q;
    logic [LEN_W-1:0] len_out_q;

    logic          req_rdy, accept, enter_done;
    logic          stk_push, stk_pop, stk_flush, stk_empty, stk_full;
    vertex_t       stk_top;
    logic [LEN_W-1:0] stk_count;
    logic [IDX_W-1:0] tgt_idx, cur_idx;

    assign tgt_idx    = target_q[IDX_W-1:0];
    assign cur_idx    = cur_q[IDX_W-1:0];
    assign hop_inc    = hop_q + 1'b1;
    assign req_rdy    = (state_q == S_IDLE) && !result_rdy_i && !rst;
    assign accept     = trace_req_i && req_rdy;
    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

    dj_path_stack #(
        .DEPTH (MAX_VIRTEX_NUM),
        .WIDTH (VIRTEX_NUM_WIDTH),
        .CNT_W (LEN_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .flush_i (stk_flush),
        .data_i  (cur_q),
        .top_o   (stk_top),
        .count_o (stk_count),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and walk/stack control.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        hop_d      = hop_q;
        walk_len_d = walk_len_q;
        pend_d     = pend_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_flush  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!snap_valid_q) begin
                    pend_d  = ST_NO_RESULT;
                    state_d = S_DONE;
                end else if ((target_q >= num_q) || ({1'b0, target_q} >= MAX_L)) begin
                    pend_d  = ST_BAD_TARGET;
                    state_d = S_DONE;
                end else if (dist_q[tgt_idx] == DIST_INF) begin
                    pend_d  = ST_UNREACH;
                    state_d = S_DONE;
                end else begin
                    pend_d  = ST_OK;
                    cur_d   = target_q;
                    hop_d   = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                stk_push = !stk_full;
                hop_d    = hop_inc;
                if (cur_q == init_q) begin
                    walk_len_d = hop_inc;
                    state_d    = S_EMIT;
                end else if (hop_inc == MAX_L) begin
                    stk_flush = 1'b1;
                    pend_d    = ST_LOOP;
                    state_d   = S_DONE;
                end else begin
                    cur_d = route_q[cur_idx];
                end
            end
            S_EMIT: begin
                if (path_ready_i && !stk_empty) begin
                    stk_pop = 1'b1;
                    if (stk_count == LEN_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and stack top.
    always_comb begin
        trace_req_rdy_o = req_rdy;
        path_valid_o    = (state_q == S_EMIT);
        path_vertex_o   = (state_q == S_EMIT) ? stk_top : '0;
        path_last_o     = (state_q == S_EMIT) && (stk_count == LEN_W'(1));
        trace_done_o    = (state_q == S_DONE);
        result_lost_o   = lost_q;
        trace_status_o  = status_q;
        path_dist_o     = dist_out_q;
        path_len_o      = len_out_q;
    end

    // Snapshot, walk datapath and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q       <= '0;
            route_q      <= '0;
            snap_valid_q <= 1'b0;
            init_q       <= '0;
            num_q        <= '0;
            target_q     <= '0;
            cur_q        <= '0;
            hop_q        <= '0;
            walk_len_q   <= '0;
            pend_q       <= ST_OK;
            lost_q       <= 1'b0;
            status_q     <= ST_OK;
            dist_out_q   <= '0;
            len_out_q    <= '0;
        end else begin
            lost_q <= result_rdy_i && (state_q != S_IDLE);
            if (result_rdy_i && (state_q == S_IDLE)) begin
                dist_q       <= dist_vect_i;
                route_q      <= route_vect_i;
                init_q       <= res_virt_init_i;
                num_q        <= res_virt_num_i;
                snap_valid_q <= !error_i;
            end
            if (accept) target_q <= trace_target_i;
            cur_q      <= cur_d;
            hop_q      <= hop_d;
            walk_len_q <= walk_len_d;
            pend_q     <= pend_d;
            if (enter_done) begin
                status_q <= pend_d;
                if (pend_d == ST_OK) begin
                    dist_out_q <= dist_q[tgt_idx];
                    len_out_q  <= walk_len_q;
                end else begin
                    dist_out_q <= '0;
                    len_out_q  <= '0;
                end
            end
        end
    end

endmodule
